// File: rtl/puck_pkg.sv
// ----------------------------------------------------------------------------
// puck_pkg
// Shared constants for the UART transmit arbiter.
//   - Sequencer state encoding (2-bit, legacy-compatible constants).
//   - Requester ids: REQ_MON (monitor) and REQ_CPU (CPU).
// ----------------------------------------------------------------------------
package puck_pkg;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_SEND       = 2'd1;
    localparam logic [1:0] ST_WAIT_START = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE  = 2'd3;

    localparam logic REQ_MON = 1'b0;
    localparam logic REQ_CPU = 1'b1;

endpackage

// File: rtl/txarb_fifo.sv
// ----------------------------------------------------------------------------
// txarb_fifo
// Per-requester byte FIFO feeding the UART transmit arbiter.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   push, din : push strobe and byte; dropped when full
//   pop       : remove the head entry (ignored when empty)
//   full      : FIFO holds DEPTH entries
//   empty     : FIFO holds no entries
//   overflow  : sticky, set when a push is dropped; cleared only by reset
//   head      : oldest entry (valid while not empty)
// ----------------------------------------------------------------------------
module txarb_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic [7:0] head
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Full is judged on the pre-pop count, so a push into a full FIFO is
    // dropped even when the same edge frees an entry.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers are PTR_W bits wide and DEPTH is a power of two, so they
    // wrap modulo DEPTH by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full) overflow <= 1'b1;
        end
    end

    // Storage carries data only and needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between requester 0 (monitor) and requester 1
// (CPU). Each requester pushes into a private FIFO; a four-state sequencer
// pops one byte at a time, pulses transmit and waits for the UART to finish.
//
// Configuration macro: TXARB_PRIORITY_EN
//   defined     -> fixed priority, requester 0 wins whenever it is eligible
//   not defined -> round-robin between requesters on ties
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   reqN_byte           : requester N data byte
//   reqN_transmit       : requester N one-cycle push strobe
//   reqN_full           : requester N FIFO holds DEPTH entries
//   reqN_busy           : requester N FIFO non-empty or its byte in flight
//   reqN_overflow       : sticky, requester N push was dropped
//   tx_byte             : byte driven to the UART
//   transmit            : one-cycle start pulse to the UART
//   is_transmitting     : UART busy flag
//   grant               : requester owning the current or last byte
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import puck_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req0_byte,
    input  logic       req0_transmit,
    output logic       req0_full,
    output logic       req0_busy,
    output logic       req0_overflow,
    input  logic [7:0] req1_byte,
    input  logic       req1_transmit,
    output logic       req1_full,
    output logic       req1_busy,
    output logic       req1_overflow,
    output logic [7:0] tx_byte,
    output logic       transmit,
    input  logic       is_transmitting,
    output logic       grant
);

    logic [1:0] state;
    logic       empty0, empty1;
    logic [7:0] head0, head1;
    logic       pop0, pop1;
    logic       sel;
    logic       start;

    txarb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo0 (
        .clk      (clk),
        .rst      (rst),
        .push     (req0_transmit),
        .din      (req0_byte),
        .pop      (pop0),
        .full     (req0_full),
        .empty    (empty0),
        .overflow (req0_overflow),
        .head     (head0)
    );

    txarb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo1 (
        .clk      (clk),
        .rst      (rst),
        .push     (req1_transmit),
        .din      (req1_byte),
        .pop      (pop1),
        .full     (req1_full),
        .empty    (empty1),
        .overflow (req1_overflow),
        .head     (head1)
    );

`ifdef TXARB_PRIORITY_EN
    assign sel = !empty0 ? REQ_MON : REQ_CPU;
`else
    logic last_grant;

    // On a tie the requester that did not own the previous byte wins.
    assign sel = (!empty0 && !empty1) ? !last_grant :
                 (!empty0 ? REQ_MON : REQ_CPU);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= REQ_CPU;
        end else if (state == ST_WAIT_DONE && !is_transmitting) begin
            last_grant <= grant;
        end
    end
`endif

    // A new byte is only launched from IDLE while the UART reports idle.
    assign start = (state == ST_IDLE) && !is_transmitting && (!empty0 || !empty1);
    assign pop0  = start && (sel == REQ_MON);
    assign pop1  = start && (sel == REQ_CPU);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            transmit <= 1'b0;
            tx_byte  <= 8'h00;
            grant    <= REQ_MON;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tx_byte  <= (sel == REQ_CPU) ? head1 : head0;
                        grant    <= sel;
                        transmit <= 1'b1;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    transmit <= 1'b0;
                    state    <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (is_transmitting) state <= ST_WAIT_DONE;
                end
                default: begin
                    if (!is_transmitting) state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_busy = !empty0 || ((state != ST_IDLE) && (grant == REQ_MON));
    assign req1_busy = !empty1 || ((state != ST_IDLE) && (grant == REQ_CPU));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Randomized bench for uart_tx_arbiter. Stimulus appends accepted bytes to
// per-requester reference queues; a monitor pops the expected byte whenever
// the DUT pulses transmit. A simple UART model answers each pulse with a
// randomly delayed, randomly long busy window.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int DEPTH = 4;
`ifdef TXARB_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req0_byte = 8'h00;
    logic       req0_transmit = 1'b0;
    logic       req0_full, req0_busy, req0_overflow;
    logic [7:0] req1_byte = 8'h00;
    logic       req1_transmit = 1'b0;
    logic       req1_full, req1_busy, req1_overflow;
    logic [7:0] tx_byte;
    logic       transmit;
    logic       is_transmitting = 1'b0;
    logic       grant;

    uart_tx_arbiter #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .req0_byte       (req0_byte),
        .req0_transmit   (req0_transmit),
        .req0_full       (req0_full),
        .req0_busy       (req0_busy),
        .req0_overflow   (req0_overflow),
        .req1_byte       (req1_byte),
        .req1_transmit   (req1_transmit),
        .req1_full       (req1_full),
        .req1_busy       (req1_busy),
        .req1_overflow   (req1_overflow),
        .tx_byte         (tx_byte),
        .transmit        (transmit),
        .is_transmitting (is_transmitting),
        .grant           (grant)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit  last_win     = 1'b1;
    bit  inflight     = 1'b0;
    bit  inflight_req = 1'b0;
    bit  uart_done    = 1'b0;
    bit  popped0      = 1'b0;
    bit  popped1      = 1'b0;
    bit  ovf0         = 1'b0;
    bit  ovf1         = 1'b0;
    int  tx_pulses    = 0;
    int  busy_lo      = 2;
    int  busy_hi      = 5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // UART model: busy window starts 1..3 cycles after the pulse.
    initial begin
        int d, b;
        forever begin
            @(posedge clk);
            #1;
            if (transmit && !rst) begin
                d = $urandom_range(1, 3);
                b = $urandom_range(busy_lo, busy_hi);
                repeat (d) @(negedge clk);
                is_transmitting = 1'b1;
                repeat (b) @(negedge clk);
                is_transmitting = 1'b0;
                uart_done = 1'b1;
            end
        end
    end

    // Monitor / scoreboard
    always @(posedge clk) begin
        bit w;
        logic [7:0] eb;
        #1;
        popped0 = 1'b0;
        popped1 = 1'b0;
        if (!rst) begin
            if (uart_done) begin
                uart_done = 1'b0;
                inflight  = 1'b0;
            end
            if (transmit) begin
                tx_pulses++;
                if (q0.size() == 0 && q1.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_transmit tx_byte=%0h required=no_pulse at %0t", tx_byte, $time);
                end else begin
                    if (q0.size() != 0 && q1.size() != 0)
                        w = PRIO ? 1'b0 : !last_win;
                    else
                        w = (q0.size() != 0) ? 1'b0 : 1'b1;
                    if (w) begin
                        eb = q1.pop_front();
                        popped1 = 1'b1;
                    end else begin
                        eb = q0.pop_front();
                        popped0 = 1'b1;
                    end
                    last_win     = w;
                    inflight     = 1'b1;
                    inflight_req = w;
                    check("grant", {31'd0, grant}, {31'd0, w});
                    check("tx_byte", {24'd0, tx_byte}, {24'd0, eb});
                end
            end
        end
    end

    // One clock of stimulus plus per-cycle status checks.
    task automatic step(input bit p0, input logic [7:0] b0, input bit p1, input logic [7:0] b1);
        @(negedge clk);
        req0_transmit = p0;
        req0_byte     = b0;
        req1_transmit = p1;
        req1_byte     = b1;
        @(posedge clk);
        #2;
        if (p0) begin
            if (q0.size() + int'(popped0) >= DEPTH) ovf0 = 1'b1;
            else q0.push_back(b0);
        end
        if (p1) begin
            if (q1.size() + int'(popped1) >= DEPTH) ovf1 = 1'b1;
            else q1.push_back(b1);
        end
        #1;
        req0_transmit = 1'b0;
        req1_transmit = 1'b0;
        check("req0_full", {31'd0, req0_full}, {31'd0, q0.size() == DEPTH});
        check("req1_full", {31'd0, req1_full}, {31'd0, q1.size() == DEPTH});
        check("req0_overflow", {31'd0, req0_overflow}, {31'd0, ovf0});
        check("req1_overflow", {31'd0, req1_overflow}, {31'd0, ovf1});
        check("req0_busy", {31'd0, req0_busy},
              {31'd0, (q0.size() != 0) || (inflight && !inflight_req)});
        check("req1_busy", {31'd0, req1_busy},
              {31'd0, (q1.size() != 0) || (inflight && inflight_req)});
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || inflight) && n < limit) begin
            step(1'b0, 8'h00, 1'b0, 8'h00);
            n++;
        end
        tests++;
        if (n >= limit) begin
            fails++;
            $display("FAIL drain_timeout remaining=%0d required=0", q0.size() + q1.size());
        end
    endtask

    initial begin
        int n;
        int pulses_before;
        int prob;

        repeat (3) @(negedge clk);
        #1;
        check("rst_transmit", {31'd0, transmit}, 32'd0);
        check("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        check("rst_grant", {31'd0, grant}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Idle: no pulses, all status low.
        repeat (10) step(1'b0, 8'h00, 1'b0, 8'h00);
        check("idle_no_pulse", tx_pulses, 0);

        // Single byte latency: pulse at the second edge after the push.
        busy_lo = 20;
        busy_hi = 20;
        step(1'b1, 8'h41, 1'b0, 8'h00);
        check("pre_pulse_transmit", {31'd0, transmit}, 32'd0);
        @(posedge clk);
        #4;
        check("pulse_transmit", {31'd0, transmit}, 32'd1);
        check("pulse_tx_byte", {24'd0, tx_byte}, 32'h41);
        check("pulse_grant", {31'd0, grant}, 32'd0);
        drain(100);

        // Randomized phases: short/long UART busy, light to saturating load.
        for (int ph = 0; ph < 6; ph++) begin
            if (ph % 2 == 0) begin
                busy_lo = 2;
                busy_hi = 5;
            end else begin
                busy_lo = 12;
                busy_hi = 20;
            end
            prob = (ph < 2) ? 20 : ((ph < 4) ? 50 : 100);
            repeat (150) begin
                step($urandom_range(0, 99) < prob, 8'($urandom),
                     $urandom_range(0, 99) < prob, 8'($urandom));
            end
            drain(400);
        end

        // Reset mid-byte with both FIFOs holding data.
        busy_lo = 30;
        busy_hi = 30;
        step(1'b1, 8'h10, 1'b1, 8'h20);
        step(1'b1, 8'h11, 1'b1, 8'h21);
        n = 0;
        while (!(inflight && is_transmitting) && n < 50) begin
            step(1'b0, 8'h00, 1'b0, 8'h00);
            n++;
        end
        check("reach_wait_done", {31'd0, inflight && is_transmitting}, 32'd1);
        step(1'b0, 8'h00, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        q0.delete();
        q1.delete();
        inflight = 1'b0;
        last_win = 1'b1;
        ovf0     = 1'b0;
        ovf1     = 1'b0;
        #1;
        check("midrst_transmit", {31'd0, transmit}, 32'd0);
        check("midrst_tx_byte", {24'd0, tx_byte}, 32'd0);
        check("midrst_grant", {31'd0, grant}, 32'd0);
        check("midrst_busy", {30'd0, req1_busy, req0_busy}, 32'd0);
        check("midrst_full", {30'd0, req1_full, req0_full}, 32'd0);
        check("midrst_overflow", {30'd0, req1_overflow, req0_overflow}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses_before = tx_pulses;
        repeat (60) step(1'b0, 8'h00, 1'b0, 8'h00);
        check("no_send_after_reset", tx_pulses, pulses_before);

        // Traffic resumes normally after reset.
        busy_lo = 2;
        busy_hi = 6;
        repeat (80) begin
            step($urandom_range(0, 99) < 60, 8'($urandom),
                 $urandom_range(0, 99) < 60, 8'($urandom));
        end
        drain(400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout time=%0t required=finish_earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between two byte producers: requester 0 (monitor) and requester 1 (CPU). Each requester has a private byte FIFO, so neither producer has to wait for the other. The block sits between both producers and the UART's `transmit`/`tx_byte` inputs, replacing the static owner mux. A four-state sequencer pops one byte at a time, pulses `transmit`, and tracks `is_transmitting` until the byte is finished.

## Interface
Parameters:
- `DEPTH`, 4: entries per requester FIFO; power of two, at least 2.
- `PTR_W`, $clog2(DEPTH): FIFO pointer width; derived, do not override.

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_byte` in 8: requester 0 data.
- `req0_transmit` in 1: one-cycle push strobe for requester 0.
- `req0_full` out 1: requester 0 FIFO holds `DEPTH` entries.
- `req0_busy` out 1: requester 0 FIFO is non-empty, or a requester 0 byte is in flight.
- `req0_overflow` out 1: sticky; set when a requester 0 push is dropped.
- `req1_byte`, `req1_transmit`, `req1_full`, `req1_busy`, `req1_overflow`: same as requester 0, for requester 1.
- `tx_byte` out 8: byte driven to the UART.
- `transmit` out 1: one-cycle start pulse to the UART.
- `is_transmitting` in 1: UART busy flag.
- `grant` out 1: requester owning the current or last byte.

## Operation
Reset values:
- `transmit`=0, `tx_byte`=0, `grant`=0.
- FIFOs empty; `full`/`busy`/`overflow` all 0.
- State IDLE; `last_grant`=1, so requester 0 wins the first tie.

Push rules:
- A push is accepted when the strobe is high and `full` is 0. `full` is sampled before any same-cycle pop.
- A push while full is dropped, leaves the FIFO unchanged, and sets that requester's `overflow`. Only reset clears `overflow`.

Sequencer states:
- IDLE:
  - Eligible requesters are those whose FIFO is non-empty; leave IDLE only when `is_transmitting`=0.
  - One eligible requester: select it. Both eligible: select `!last_grant`.
  - On selection: register the FIFO head into `tx_byte`, pop that FIFO, set `grant`, set `transmit`<=1, go to SEND.
- SEND: `transmit` is high for this cycle only; `transmit`<=0; go to WAIT_START.
- WAIT_START: when `is_transmitting`=1, go to WAIT_DONE.
- WAIT_DONE: when `is_transmitting`=0, set `last_grant`<=`grant` and go to IDLE.

Other rules:
- `busy` = FIFO non-empty, OR (state is not IDLE AND `grant` equals that requester).
- FIFO pointers wrap modulo `DEPTH`. Occupancy uses a `PTR_W+1`-bit count.
- A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Asserting `rst` mid-byte returns immediately to reset values. All queued bytes are discarded and `transmit` drops at once.
- The UART line may still finish its current frame; it is not tracked after reset.

## Timing
- Push at edge t: count visible after t. IDLE selects at edge t+1. `transmit` is high during cycle t+1..t+2, i.e. 2 cycles push-to-pulse.
- `tx_byte` is stable from the `transmit` pulse until the next selection.
- Minimum gap between consecutive pulses is 2 cycles plus the UART busy time. IDLE is always visited between bytes.
- If `is_transmitting` never rises, WAIT_START holds indefinitely. This is an integration error; no timeout is provided.

## Configuration
- `TXARB_PRIORITY_EN` defined: fixed priority. Requester 0 always wins when eligible; `last_grant` is unused.
- Not defined: round-robin, as described above.
- All other behaviour is identical either way.

## Structure
- Shared package `puck_pkg`: state encoding localparams (IDLE=0, SEND=1, WAIT_START=2, WAIT_DONE=3) and requester ids (REQ_MON=0, REQ_CPU=1).
- One sub-module, `txarb_fifo`: push/pop/full/empty/head FIFO, instantiated twice.

## Test plan
- Reset, then idle with `is_transmitting`=0 → `transmit` never pulses; all outputs stay 0.
- Push 0x41 on requester 0 at cycle 10 → `transmit` high in cycle 12 with `tx_byte`=0x41 and `grant`=0. Model UART busy for 20 cycles → `busy` falls the cycle after `is_transmitting` falls.
- Both requesters hold 2 bytes (0x10,0x11 / 0x20,0x21), round-robin build → send order 0x10, 0x20, 0x11, 0x21. With `TXARB_PRIORITY_EN` → 0x10, 0x11, 0x20, 0x21.
- Push `DEPTH`+1 bytes to requester 1 while the UART is held busy → `req1_full`=1 after the 4th push; 5th byte dropped; `req1_overflow`=1; only 4 bytes are later sent.
- Push on a full FIFO in the same cycle as its pop → push dropped, overflow set, count becomes `DEPTH`-1.
- Assert `rst` during WAIT_DONE with both FIFOs non-empty → `transmit`=0; `busy` and `full` go to 0; no further bytes sent after release.
